memory_access: RTL

- Memory stage directly upstream of the writeback stage.
- Accepts one operation per handshake from execute and performs data-memory loads/stores over a simple req/ready bus.
- Aligns and extends load data, then presents a registered result bundle to writeback: result, pc_address, reg_dest, write_en, branch_link.
- Non-memory operations pass through with one cycle of latency.

---
 rtl/memory_access.sv | 134 +++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// memory_access: memory stage; bus loads/stores with lane alignment, registered writeback bundle. Ports: execute handshake (in_*), req/ready data bus (mem_*), writeback bundle (out_valid, result, pc_address, reg_dest, write_en, branch_link, addr_error, bad_vaddr).
module memory_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_signed,
  input  logic [31:0]       in_pc_address,
  input  logic [4:0]        in_reg_dest,
  input  logic              in_write_en,
  input  logic              in_branch_link,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [31:0]       pc_address,
  output logic [4:0]        reg_dest,
  output logic              write_en,
  output logic              branch_link,
  output logic              addr_error,
  output logic [DATA_W-1:0] bad_vaddr
);
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] addr_q, wdata_q, ld;
  logic [1:0] size_q, off;
  logic [3:0] be_q, be_c;
  logic [31:0] p_pc;
  logic [4:0] p_rd;
  logic sgn_q, wr_q, p_we, p_bl, is_mem, mis, go;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [DATA_W-1:0] wdata_c;
  assign off = in_alu_result[1:0];
  assign is_mem = in_mem_read | in_mem_write;
  assign mis = is_mem & (in_mem_size == 2'd0 ? 1'b0 : in_mem_size == 2'd1 ? off[0] : |off);
  assign go = in_valid & (state == IDLE);
  assign be_c = in_mem_size == 2'd0 ? 4'b0001 << off : in_mem_size == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_c = in_mem_size == 2'd0 ? {4{in_store_data[7:0]}} : in_mem_size == 2'd1 ? {2{in_store_data[15:0]}} : in_store_data;
  assign byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // Reserved size 3 behaves as a word access throughout.
  assign ld = size_q == 2'd0 ? {{24{sgn_q & byte_v[7]}}, byte_v} : size_q == 2'd1 ? {{16{sgn_q & half_v[15]}}, half_v} : mem_rdata;
  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_we = mem_req & wr_q;
  assign mem_be = mem_req ? be_q : 4'b0000;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_req = 1'b0;
    if (state == IDLE) begin
      in_ready = 1'b1;
      if (go && is_mem && !mis) state_nx = BUS;
    end else begin
      mem_req = 1'b1;
      if (mem_ready) state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      be_q <= '0;
      sgn_q <= 1'b0;
      wr_q <= 1'b0;
      p_pc <= '0;
      p_rd <= '0;
      p_we <= 1'b0;
      p_bl <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      pc_address <= '0;
      reg_dest <= '0;
      write_en <= 1'b0;
      branch_link <= 1'b0;
      addr_error <= 1'b0;
      bad_vaddr <= '0;
    end else begin
      out_valid <= 1'b0;
      write_en <= 1'b0;
      branch_link <= 1'b0;
      addr_error <= 1'b0;
      if (go && is_mem && !mis) begin
        addr_q <= in_alu_result;
        wdata_q <= wdata_c;
        size_q <= in_mem_size;
        be_q <= be_c;
        sgn_q <= in_mem_signed;
        wr_q <= in_mem_write;
        p_pc <= in_pc_address;
        p_rd <= in_reg_dest;
        p_we <= in_write_en;
        p_bl <= in_branch_link;
      end
      // Non-memory ops and misaligned accesses retire straight from the accept edge.
      if (go && (!is_mem || mis)) begin
        out_valid <= 1'b1;
        result <= in_alu_result;
        pc_address <= in_pc_address;
        reg_dest <= in_reg_dest;
        write_en <= in_write_en & !is_mem;
        branch_link <= in_branch_link & !is_mem;
        addr_error <= mis;
        if (mis) bad_vaddr <= in_alu_result;
      end
      if (state == BUS && mem_ready) begin
        out_valid <= 1'b1;
        result <= wr_q ? addr_q : ld;
        pc_address <= p_pc;
        reg_dest <= p_rd;
        write_en <= p_we & !wr_q;
        branch_link <= p_bl;
      end
    end
  end
endmodule
